// File: rtl/local_injection_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one router local injection port among
// NUM_REQ on-tile sources; registered flit output honours the router's full backpressure.
module local_injection_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned FLIT_W      = 17,
  parameter int unsigned MAX_PKT_LEN = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  input  logic [NUM_REQ*FLIT_W-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic                        local_full_i,
  output logic [FLIT_W-1:0]           inj_data_o,
  output logic [$clog2(NUM_REQ)-1:0]  grant_o,
  output logic                        busy_o,
  output logic                        len_err_o
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              r_state, w_state_nx;
  logic [GW-1:0]       r_grant, w_grant_nx;
  logic [GW-1:0]       r_rr_ptr, w_rr_ptr_nx;
  logic [CW-1:0]       r_count, w_count_nx;
  logic [FLIT_W-1:0]   r_inj, w_inj_nx;
  logic                r_len_err, w_len_err_nx;
  logic [NUM_REQ-1:0]  w_ready;
  logic [GW-1:0]       w_sel;
  logic                w_any;
  logic                w_out_free;

  // The held flit may be replaced unless it is valid and the router is full.
  assign w_out_free = !r_inj[FLIT_W-1] || !local_full_i;

  // First requesting source after rr_ptr, wrapping.
  always_comb begin
    int unsigned v_idx;
    logic [GW-1:0] v_pos;
    v_idx = 0;
    v_pos = '0;
    w_sel = '0;
    w_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      v_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
      v_pos = GW'(v_idx);
      if (!w_any && req_valid_i[v_pos]) begin
        w_any = 1'b1;
        w_sel = v_pos;
      end
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_rr_ptr_nx  = r_rr_ptr;
    w_count_nx   = r_count;
    w_inj_nx     = r_inj;
    w_len_err_nx = 1'b0;
    w_ready      = '0;
    case (r_state)
      IDLE: begin
        if (w_out_free) w_inj_nx = '0;
        if (w_any) begin
          w_grant_nx = w_sel;
          w_state_nx = SEND;
        end
      end
      SEND: begin
        w_ready[r_grant] = req_valid_i[r_grant] && w_out_free;
        if (w_ready[r_grant]) begin
          w_inj_nx             = req_data_i[32'(r_grant)*FLIT_W +: FLIT_W];
          w_inj_nx[FLIT_W-1]   = 1'b1;
          // A packet reaching the length limit is closed as if the flit were its tail.
          if (req_last_i[r_grant] || (r_count == CW'(MAX_PKT_LEN - 1))) begin
            w_len_err_nx = !req_last_i[r_grant];
            w_rr_ptr_nx  = r_grant;
            w_count_nx   = '0;
            w_state_nx   = IDLE;
          end else begin
            w_count_nx = r_count + CW'(1);
          end
        end else if (w_out_free) begin
          w_inj_nx = '0;
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= GW'(NUM_REQ - 1);
      r_count   <= '0;
      r_inj     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_rr_ptr  <= w_rr_ptr_nx;
      r_count   <= w_count_nx;
      r_inj     <= w_inj_nx;
      r_len_err <= w_len_err_nx;
    end
  end

  assign req_ready_o = w_ready;
  assign inj_data_o  = r_inj;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == SEND);
  assign len_err_o   = r_len_err;

endmodule
